// File: rtl/serial_frame_rx.sv
// -----------------------------------------------------------------------------
// serial_frame_rx
//   Negedge-clocked serial frame receiver. Takes a one-bit line (idle high),
//   detects a start bit (0), shifts in WIDTH data bits LSB-first, then an
//   optional even-parity bit, then a stop bit (1). A good frame is presented
//   on a valid/ready parallel interface and held until it is taken.
//
//   Build option: define SERIAL_FRAME_RX_PARITY_EN to expect an even-parity
//   bit between the last data bit and the stop bit. Without it there is no
//   parity bit and PERR stays 0.
//
// Ports
//   CLK      in   clock, all state changes on the falling edge
//   RESET_N  in   asynchronous active-low reset
//   CE       in   sample enable; gates line sampling, not the handshake
//   SDIN     in   serial line, idle high
//   READY    in   consumer ready
//   PDATA    out  received payload, bit 0 = first data bit
//   VALID    out  PDATA holds an undelivered frame
//   PERR     out  parity error for the frame on PDATA
//   FERR     out  one-cycle pulse, stop bit sampled 0 and frame dropped
//   OVERRUN  out  sticky, start bit seen while a frame was undelivered
//   BUSY     out  receiver is shifting a frame
// -----------------------------------------------------------------------------
module serial_frame_rx #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             CE,
    input  logic             SDIN,
    input  logic             READY,
    output logic [WIDTH-1:0] PDATA,
    output logic             VALID,
    output logic             PERR,
    output logic             FERR,
    output logic             OVERRUN,
    output logic             BUSY
);

`ifdef SERIAL_FRAME_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    // Bit counter indexes the bits after the start bit: data, parity, stop.
    localparam int               CNT_W    = $clog2(WIDTH + PAR_BITS + 1);
    localparam logic [CNT_W-1:0] STOP_IDX = CNT_W'(WIDTH + PAR_BITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [WIDTH-1:0]   pdata_q, pdata_d;
    logic               valid_q, valid_d;
    logic               perr_q, perr_d;
    logic               ferr_q, ferr_d;
    logic               overrun_q, overrun_d;
    logic               busy_q, busy_d;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic               par_q, par_d;
`endif

    logic start_seen;
    logic par_err;

    assign start_seen = CE & ~SDIN;

`ifdef SERIAL_FRAME_RX_PARITY_EN
    // Even parity: data bits plus parity bit must XOR to zero.
    assign par_err = (^sh_q) ^ par_q;
`else
    assign par_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        pdata_d   = pdata_q;
        valid_d   = valid_q;
        perr_d    = perr_q;
        ferr_d    = 1'b0;
        overrun_d = overrun_q;
`ifdef SERIAL_FRAME_RX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_seen) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end
            end
            S_SHIFT: begin
                if (CE) begin
                    if (cnt_q == STOP_IDX) begin
                        cnt_d = '0;
                        if (SDIN) begin
                            pdata_d = sh_q;
                            valid_d = 1'b1;
                            perr_d  = par_err;
                            state_d = S_HOLD;
                        end else begin
                            // Bad stop: drop the frame, previous PDATA/VALID untouched.
                            ferr_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        if (cnt_q == CNT_W'(WIDTH))
                            par_d = SDIN;
                        else
                            sh_d = {SDIN, sh_q[WIDTH-1:1]};
`else
                        // Shift in from the top so the first bit lands in bit 0.
                        sh_d = {SDIN, sh_q[WIDTH-1:1]};
`endif
                    end
                end
            end
            S_HOLD: begin
                if (valid_q && READY) begin
                    valid_d = 1'b0;
                    perr_d  = 1'b0;
                    // A start bit on the transfer edge re-arms immediately.
                    if (start_seen) begin
                        state_d = S_SHIFT;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (start_seen) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_SHIFT);
    end

    always_ff @(negedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            pdata_q   <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            pdata_q   <= pdata_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign PDATA   = pdata_q;
    assign VALID   = valid_q;
    assign PERR    = perr_q;
    assign FERR    = ferr_q;
    assign OVERRUN = overrun_q;
    assign BUSY    = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_rx
//   Self-checking bench for serial_frame_rx (WIDTH=8). Frames are built from
//   payload bytes; expectations come from the payload, the chosen stop and
//   parity bits, and the handshake rules.
// -----------------------------------------------------------------------------
module tb_serial_frame_rx;
    localparam int W = 8;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         CLK = 1'b1;
    logic         RESET_N = 1'b0;
    logic         CE = 1'b1;
    logic         SDIN = 1'b1;
    logic         READY = 1'b0;
    logic [W-1:0] PDATA;
    logic         VALID, PERR, FERR, OVERRUN, BUSY;

    int n_chk  = 0;
    int n_fail = 0;

    serial_frame_rx #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CE(CE), .SDIN(SDIN), .READY(READY),
        .PDATA(PDATA), .VALID(VALID), .PERR(PERR), .FERR(FERR),
        .OVERRUN(OVERRUN), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One active (falling) edge, then settle before sampling.
    task automatic tick();
        @(negedge CLK);
        #2;
    endtask

    function automatic logic [31:0] all_outs();
        return {19'd0, VALID, PERR, FERR, OVERRUN, BUSY, PDATA};
    endfunction

    function automatic logic exp_perr(input logic [W-1:0] d, input logic p);
        return PAR ? ((^d) ^ p) : 1'b0;
    endfunction

    // Drives one frame. stall_at = data bit index before which CE drops for
    // stall_len edges (stall_at >= W means no stall).
    task automatic send_frame(input logic [W-1:0] d, input logic stop, input logic par_bit,
                              input bit skip_start, input int stall_at, input int stall_len,
                              input bit rdy_rand);
        READY = 1'b0;
        if (!skip_start) begin
            CE = 1'b1; SDIN = 1'b0;
            tick();
            chk("start_busy", BUSY, 1);
        end
        for (int i = 0; i < W; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    CE = 1'b0; SDIN = 1'($urandom);
                    if (rdy_rand) READY = 1'($urandom);
                    tick();
                    chk("stall_busy", BUSY, 1);
                end
            end
            CE = 1'b1; SDIN = d[i];
            if (rdy_rand) READY = 1'($urandom);
            tick();
        end
        if (PAR) begin
            SDIN = par_bit;
            tick();
        end
        chk("pre_stop", {VALID, BUSY}, 2'b01);
        SDIN = stop;
        tick();
        SDIN = 1'b1; READY = 1'b0;
        if (stop) begin
            chk("stop_valid", {VALID, BUSY, FERR}, 3'b100);
            chk("stop_pdata", PDATA, d);
            chk("stop_perr", PERR, exp_perr(d, par_bit));
        end else begin
            chk("ferr_pulse", {FERR, VALID, BUSY}, 3'b100);
            tick();
            chk("ferr_gone", {FERR, VALID, BUSY}, 3'b000);
        end
    endtask

    task automatic deliver(input logic [W-1:0] d);
        READY = 1'b1; SDIN = 1'b1; CE = 1'b1;
        tick();
        READY = 1'b0;
        chk("xfer_valid", {VALID, PERR, BUSY}, 3'b000);
        chk("xfer_pdata_kept", PDATA, d);
    endtask

    logic [W-1:0] d;
    logic         stop, pb;
    bit           skip;

    initial begin
        // Reset and idle line.
        tick();
        chk("reset_outs", all_outs(), 0);
        RESET_N = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle", {VALID, BUSY, FERR, OVERRUN}, 4'b0000);
        end

        // Good frame 0xA5 held with READY=0.
        send_frame(8'hA5, 1'b1, ^8'hA5, 0, W, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_a5", {VALID, PDATA}, {1'b1, 8'hA5});
        end
        deliver(8'hA5);

        // Framing error then a good frame.
        send_frame(8'h3C, 1'b0, ^8'h3C, 0, W, 0, 0);
        chk("ferr_pdata_kept", PDATA, 8'hA5);
        send_frame(8'h11, 1'b1, ^8'h11, 0, W, 0, 0);
        deliver(8'h11);

        // CE stall of 3 edges mid-data.
        send_frame(8'h5A, 1'b1, ^8'h5A, 0, 4, 3, 0);
        deliver(8'h5A);

        // Overrun: start bit while frame held.
        send_frame(8'h01, 1'b1, ^8'h01, 0, W, 0, 0);
        SDIN = 1'b0; CE = 1'b1;
        tick();
        chk("overrun_set", {OVERRUN, VALID, BUSY}, 3'b110);
        SDIN = 1'b1;
        tick();
        chk("overrun_pdata", PDATA, 8'h01);
        deliver(8'h01);
        chk("overrun_sticky", OVERRUN, 1);

        // Async reset in HOLD with overrun set.
        send_frame(8'hC3, 1'b1, ^8'hC3, 0, W, 0, 0);
        #3 RESET_N = 1'b0;
        #1 chk("async_rst_hold", all_outs(), 0);
        tick();
        RESET_N = 1'b1;

        // Transfer and start bit on the same edge.
        send_frame(8'h01, 1'b1, ^8'h01, 0, W, 0, 0);
        READY = 1'b1; SDIN = 1'b0; CE = 1'b1;
        tick();
        chk("xfer_start", {VALID, BUSY, OVERRUN}, 3'b010);
        send_frame(8'h02, 1'b1, ^8'h02, 1, W, 0, 0);
        chk("xfer_start_ovr", OVERRUN, 0);
        deliver(8'h02);

        // Parity cases (bad parity bit, then good).
        send_frame(8'h07, 1'b1, 1'b0, 0, W, 0, 0);
        deliver(8'h07);
        send_frame(8'h07, 1'b1, 1'b1, 0, W, 0, 0);
        deliver(8'h07);

        // Async reset mid-frame.
        CE = 1'b1; SDIN = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            SDIN = 1'b1;
            tick();
        end
        chk("midframe_busy", BUSY, 1);
        #3 RESET_N = 1'b0;
        #1 chk("async_rst_mid", all_outs(), 0);
        SDIN = 1'b1;
        tick();
        RESET_N = 1'b1;
        tick();
        chk("post_rst_idle", all_outs(), 0);

        // Randomized frames with random stalls, READY noise and back-to-back.
        skip = 0;
        for (int n = 0; n < 40; n++) begin
            d    = W'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            pb   = ($urandom_range(0, 3) == 0) ? ~(^d) : ^d;
            send_frame(d, stop, pb, skip, $urandom_range(0, W), $urandom_range(0, 3), 1);
            skip = 0;
            if (stop) begin
                for (int k = $urandom_range(0, 2); k > 0; k--) begin
                    SDIN = 1'b1; READY = 1'b0; CE = 1'($urandom);
                    tick();
                    chk("rnd_hold", {VALID, PDATA}, {1'b1, d});
                end
                CE = 1'b1; READY = 1'b1;
                if ($urandom_range(0, 2) == 0) begin
                    SDIN = 1'b0;
                    tick();
                    chk("rnd_b2b", {VALID, BUSY}, 2'b01);
                    skip = 1;
                end else begin
                    SDIN = 1'b1;
                    tick();
                    chk("rnd_xfer", {VALID, BUSY}, 2'b00);
                end
                READY = 1'b0; SDIN = 1'b1;
            end
            chk("rnd_no_overrun", OVERRUN, 0);
        end
        if (skip) begin
            send_frame(8'h96, 1'b1, ^8'h96, 1, W, 0, 0);
            deliver(8'h96);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
